// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_BLANK = 4'hF;
  localparam bcd_digit_t BCD_NINE  = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } conv_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? bcd_digit_t'(digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with start/ready/done handshake, leading-zero blanking and overflow saturation.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5,
  parameter int BLANK_LZ  = 0
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int SW     = 4 * DIGITS;
  localparam int ITER_W = $clog2(BIN_WIDTH + 1);

  conv_state_t            state_q, state_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [SW-1:0]          scratch_q, scratch_d;
  logic                   sticky_q, sticky_d;
  logic [SW-1:0]          bcd_q, bcd_d;
  logic                   overflow_q, overflow_d;

  logic [SW-1:0]          adj;
  logic [SW+BIN_WIDTH-1:0] shifted;
  logic                   final_ovf;
  logic                   lead_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (scratch_q[4*g +: 4]),
      .digit_out (adj[4*g +: 4])
    );
  end

  assign shifted   = {adj, bin_q} << 1;
  assign final_ovf = sticky_q | adj[SW-1];

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    sticky_d   = sticky_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    ready      = 1'b0;
    done       = 1'b0;
    lead_zero  = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
      end
      CONVERT: begin
        scratch_d = shifted[SW+BIN_WIDTH-1:BIN_WIDTH];
        bin_d     = shifted[BIN_WIDTH-1:0];
        sticky_d  = final_ovf;
        iter_d    = iter_q - ITER_W'(1);
        if (iter_q == ITER_W'(1)) begin
          state_d    = DONE;
          overflow_d = final_ovf;
          if (final_ovf) begin
            bcd_d = {DIGITS{BCD_NINE}};
          end else begin
            bcd_d = scratch_d;
            // Blank digits above the most significant nonzero one; ones digit always shown.
            if (BLANK_LZ != 0) begin
              lead_zero = 1'b1;
              for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead_zero && (scratch_d[4*i +: 4] == 4'd0)) begin
                  bcd_d[4*i +: 4] = BCD_BLANK;
                end else begin
                  lead_zero = 1'b0;
                end
              end
            end
          end
        end
      end
      DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accepting a start from IDLE or DONE (back-to-back) loads a fresh conversion.
    if (ready && start) begin
      state_d   = CONVERT;
      bin_d     = bin_in;
      scratch_d = '0;
      sticky_d  = 1'b0;
      iter_d    = ITER_W'(BIN_WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      bin_q      <= '0;
      scratch_q  <= '0;
      sticky_q   <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      sticky_q   <= sticky_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: default, blanking and 8-bit/2-digit converters against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic [15:0] bin_in;
  logic        start_c;
  logic [7:0]  bin_c;

  logic        ready_a, done_a, ovf_a;
  logic [19:0] bcd_a;
  logic        ready_b, done_b, ovf_b;
  logic [19:0] bcd_b;
  logic        ready_c, done_c, ovf_c;
  logic [7:0]  bcd_c;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) u_dut_a (
    .clk(clk), .rst_l(rst_l), .start(start), .bin_in(bin_in),
    .ready(ready_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) u_dut_b (
    .clk(clk), .rst_l(rst_l), .start(start), .bin_in(bin_in),
    .ready(ready_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2), .BLANK_LZ(0)) u_dut_c (
    .clk(clk), .rst_l(rst_l), .start(start_c), .bin_in(bin_c),
    .ready(ready_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c)
  );

  // Decimal digits by division; saturate to all nines when the value does not fit.
  function automatic logic [19:0] model_bcd(int unsigned v, int digits, bit blank);
    logic [19:0] r;
    int unsigned limit;
    int unsigned pw;
    int msd;
    r     = '0;
    limit = 1;
    pw    = 1;
    msd   = 0;
    for (int i = 0; i < digits; i++) limit = limit * 10;
    if (v >= limit) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((v / pw) % 10);
      if (((v / pw) % 10) != 0) msd = i;
      pw = pw * 10;
    end
    if (blank) begin
      for (int i = msd + 1; i < digits; i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_ovf(int unsigned v, int digits);
    int unsigned limit;
    limit = 1;
    for (int i = 0; i < digits; i++) limit = limit * 10;
    return (v >= limit) ? 32'd1 : 32'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Counts samples from the one just after the accepting edge until done shows.
  task automatic waitDone(input bit which_c, output int n, output bit ready_bad);
    n = 1;
    ready_bad = 1'b0;
    while (!(which_c ? done_c : done_a) && n < 40) begin
      if (which_c ? ready_c : ready_a) ready_bad = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic checkResultAB(input string tag, input int unsigned v);
    checkOutput({tag, "_bcd"}, 32'(bcd_a), 32'(model_bcd(v, 5, 1'b0)));
    checkOutput({tag, "_ovf"}, 32'(ovf_a), model_ovf(v, 5));
    checkOutput({tag, "_bcd_blank"}, 32'(bcd_b), 32'(model_bcd(v, 5, 1'b1)));
    checkOutput({tag, "_ovf_blank"}, 32'(ovf_b), model_ovf(v, 5));
  endtask

  task automatic applyStimulus(input int unsigned v);
    int n;
    bit rb;
    @(negedge clk);
    bin_in = 16'(v);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    waitDone(1'b0, n, rb);
    checkOutput($sformatf("latency_%0d", v), 32'(n), 32'd17);
    checkOutput($sformatf("ready_low_%0d", v), 32'(rb), 32'd0);
    checkResultAB($sformatf("conv_%0d", v), v);
    @(negedge clk);
    checkOutput($sformatf("done_pulse_%0d", v), 32'(done_a), 32'd0);
  endtask

  task automatic applyStimulusC(input int unsigned v);
    int n;
    bit rb;
    @(negedge clk);
    bin_c   = 8'(v);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    bin_c   = 8'($urandom);
    waitDone(1'b1, n, rb);
    checkOutput($sformatf("c_latency_%0d", v), 32'(n), 32'd9);
    checkOutput($sformatf("c_ready_low_%0d", v), 32'(rb), 32'd0);
    checkOutput($sformatf("c_bcd_%0d", v), 32'(bcd_c), 32'(model_bcd(v, 2, 1'b0)));
    checkOutput($sformatf("c_ovf_%0d", v), 32'(ovf_c), model_ovf(v, 2));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n;
    bit rb;
    int dcount;
    int unsigned rv;

    // Reset held with start asserted.
    rst_l   = 1'b0;
    start   = 1'b1;
    start_c = 1'b1;
    bin_in  = 16'd1234;
    bin_c   = 8'd55;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_ready", 32'(ready_a), 32'd1);
      checkOutput("rst_done", 32'(done_a), 32'd0);
      checkOutput("rst_bcd", 32'(bcd_a), 32'd0);
      checkOutput("rst_ovf", 32'(ovf_a), 32'd0);
    end
    rst_l   = 1'b1;
    start   = 1'b0;
    start_c = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(ready_a), 32'd1);
    checkOutput("post_rst_ready_c", 32'(ready_c), 32'd1);

    // Directed default-width values, then random ones.
    applyStimulus(12345);
    applyStimulus(65535);
    applyStimulus(0);
    applyStimulus(407);
    applyStimulus(10000);
    for (int k = 0; k < 4; k++) begin
      rv = $urandom_range(0, 65535);
      applyStimulus(rv);
    end

    // Narrow converter: fit boundary, overflow saturation, and overflow clearing.
    applyStimulusC(99);
    applyStimulusC(100);
    applyStimulusC(255);
    applyStimulusC(42);
    for (int k = 0; k < 3; k++) begin
      rv = $urandom_range(0, 255);
      applyStimulusC(rv);
    end

    // Start during CONVERT is ignored; start held through DONE chains the next one.
    @(negedge clk);
    bin_in = 16'd500;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (4) @(negedge clk);
    bin_in = 16'd777;
    start  = 1'b1;
    waitDone(1'b0, n, rb);
    checkOutput("midconv_ready_low", 32'(rb), 32'd0);
    checkResultAB("midconv_500", 500);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'd3;
    waitDone(1'b0, n, rb);
    checkOutput("b2b_latency", 32'(n), 32'd17);
    checkResultAB("b2b_777", 777);

    // Reset in the middle of a conversion discards it.
    @(negedge clk);
    bin_in = 16'd9999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    dcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    checkOutput("abort_no_done", 32'(dcount), 32'd0);
    checkOutput("abort_ready", 32'(ready_a), 32'd1);
    checkOutput("abort_bcd", 32'(bcd_a), 32'd0);
    checkOutput("abort_bcd_blank", 32'(bcd_b), 32'd0);
    checkOutput("abort_ovf", 32'(ovf_a), 32'd0);
    applyStimulus(31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
